// File: rtl/parking_pkg.sv
// Shared state encoding, display codes and small helpers for the parking
// access controller.
package parking_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_GRANT = 3'd2;
  localparam state_t ST_DENY  = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_LOCK  = 3'd5;

  typedef enum logic [2:0] {
    STAT_IDLE  = 3'd0,
    STAT_WAIT  = 3'd1,
    STAT_GRANT = 3'd2,
    STAT_DENY  = 3'd3,
    STAT_STOP  = 3'd4,
    STAT_LOCK  = 3'd5
  } status_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic status_e status_of(input state_t s);
    case (s)
      ST_WAIT:  return STAT_WAIT;
      ST_GRANT: return STAT_GRANT;
      ST_DENY:  return STAT_DENY;
      ST_STOP:  return STAT_STOP;
      ST_LOCK:  return STAT_LOCK;
      default:  return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sensor_sync_edge.sv
// Two-flop synchronizer for a lane sensor followed by an edge register that
// yields a settled level plus one-cycle rise/fall pulses aligned with it.
module sensor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= async_in;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/parking_access_ctrl.sv
// Entry/exit lane controller: password gate with retry lockout, stall stop,
// occupancy counters and registered light/status outputs.
module parking_access_ctrl
  import parking_pkg::*;
#(
  parameter int                CAPACITY     = 8,
  parameter int                PASS_W       = 4,
  parameter logic [PASS_W-1:0] PASS_CODE    = 4'h5,
  parameter int                PASS_TIMEOUT = 1000,
  parameter int                MAX_TRIES    = 3,
  parameter int                LOCK_CYCLES  = 5000,
  parameter int                STALL_CYCLES = 2000,
  parameter int                BLINK_CYCLES = 25_000_000,
  parameter int                TOTAL_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sense_entry,
  input  logic                              sense_exit,
  input  logic [PASS_W-1:0]                 pass_in,
  input  logic                              pass_valid,
  output logic                              green_light,
  output logic                              red_light,
  output logic                              full,
  output logic                              locked,
  output logic [$clog2(CAPACITY+1)-1:0]     space_available,
  output logic [$clog2(CAPACITY+1)-1:0]     space_utilized,
  output logic [TOTAL_W-1:0]                count_cars,
  output logic [2:0]                        status
);

  localparam int CNT_W = $clog2(CAPACITY+1);
  localparam int T_MAX = max_int(max_int(PASS_TIMEOUT, LOCK_CYCLES), STALL_CYCLES);
  localparam int TMR_W = $clog2(T_MAX+1);
  localparam int TRY_W = $clog2(MAX_TRIES+1);
  localparam int BLK_W = max_int(1, $clog2(BLINK_CYCLES));

  logic entry_lvl, entry_rise, entry_fall;
  logic exit_lvl, exit_rise, exit_fall_unused;

  sensor_sync_edge u_entry (
    .clk(clk), .rst(rst), .async_in(sense_entry),
    .level(entry_lvl), .rise(entry_rise), .fall(entry_fall)
  );

  sensor_sync_edge u_exit (
    .clk(clk), .rst(rst), .async_in(sense_exit),
    .level(exit_lvl), .rise(exit_rise), .fall(exit_fall_unused)
  );

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [TRY_W-1:0]   tries;
  logic [TRY_W-1:0]   tries_next;
  logic [BLK_W-1:0]   blink_cnt;
  logic               blink;
  logic               pass_ok;
  logic               admit;
  logic               exit_ok;

  assign full       = (space_available == '0);
  assign pass_ok    = pass_valid && (pass_in == PASS_CODE);
  assign tries_next = tries + TRY_W'(1);
  assign admit      = (state == ST_GRANT) && entry_fall;
  assign exit_ok    = exit_rise && (space_utilized != '0);

  // One shared timer: cleared on every entry to a timed state, except DENY,
  // which keeps the password window running from WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      tries <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (entry_rise && !full) begin
            state <= ST_WAIT;
            timer <= '0;
            tries <= '0;
          end
        end
        ST_WAIT, ST_DENY: begin
          timer <= timer + TMR_W'(1);
          if (pass_ok) begin
            state <= ST_GRANT;
            timer <= '0;
          end else if (pass_valid) begin
            tries <= tries_next;
            if (tries_next >= TRY_W'(MAX_TRIES)) begin
              state <= ST_LOCK;
              timer <= '0;
            end else begin
              state <= ST_DENY;
            end
          end else if (timer == TMR_W'(PASS_TIMEOUT-1) || !entry_lvl) begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (entry_fall) begin
            state <= ST_IDLE;
          end else if (entry_lvl) begin
            timer <= timer + TMR_W'(1);
            if (timer == TMR_W'(STALL_CYCLES-1)) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (pass_ok && !entry_lvl && !exit_lvl) state <= ST_IDLE;
        end
        ST_LOCK: begin
          timer <= timer + TMR_W'(1);
          if (timer == TMR_W'(LOCK_CYCLES-1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A simultaneous admit and exit cancel on occupancy but still count the car.
  always_ff @(posedge clk) begin
    if (rst) begin
      space_available <= CNT_W'(CAPACITY);
      space_utilized  <= '0;
      count_cars      <= '0;
    end else begin
      if (admit && !exit_ok) begin
        space_available <= space_available - CNT_W'(1);
        space_utilized  <= space_utilized + CNT_W'(1);
      end else if (exit_ok && !admit) begin
        space_available <= space_available + CNT_W'(1);
        space_utilized  <= space_utilized - CNT_W'(1);
      end
      if (admit) count_cars <= count_cars + TOTAL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_CYCLES-1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      green_light <= 1'b0;
      red_light   <= 1'b0;
      locked      <= 1'b0;
      status      <= 3'd0;
    end else begin
      green_light <= (state == ST_GRANT) || ((state == ST_WAIT) && blink);
      locked      <= (state == ST_LOCK);
      status      <= status_of(state);
      case (state)
        ST_IDLE:          red_light <= full;
        ST_DENY:          red_light <= 1'b1;
        ST_STOP, ST_LOCK: red_light <= blink;
        default:          red_light <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Randomized bench for parking_access_ctrl against a car-level occupancy model.
module tb_parking_access_ctrl;

  localparam int CAP   = 8;
  localparam int LOCKN = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sense_entry = 1'b0;
  logic       sense_exit = 1'b0;
  logic [3:0] pass_in = 4'h0;
  logic       pass_valid = 1'b0;
  logic       green_light, red_light, full, locked;
  logic [3:0] space_available, space_utilized;
  logic [15:0] count_cars;
  logic [2:0] status;

  parking_access_ctrl #(.BLINK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .sense_entry(sense_entry), .sense_exit(sense_exit),
    .pass_in(pass_in), .pass_valid(pass_valid),
    .green_light(green_light), .red_light(red_light), .full(full),
    .locked(locked), .space_available(space_available),
    .space_utilized(space_utilized), .count_cars(count_cars), .status(status)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int occ   = 0;
  int total = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_status(input int code, input int budget, input string tag);
    int i = 0;
    while (int'(status) != code && i < budget) begin
      tick();
      i++;
    end
    chk(tag, int'(status), code);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_avail"}, int'(space_available), CAP - occ);
    chk({tag, "_util"},  int'(space_utilized), occ);
    chk({tag, "_total"}, int'(count_cars), total % 65536);
    chk({tag, "_full"},  int'(full), (occ == CAP) ? 1 : 0);
  endtask

  task automatic strobe(input logic [3:0] code);
    pass_in    = code;
    pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
  endtask

  task automatic wrong_code(output logic [3:0] v);
    v = 4'($urandom_range(0, 15));
    if (v == 4'h5) v = 4'h3;
  endtask

  task automatic admit_car(input int nwrong);
    logic [3:0] v;
    sense_entry = 1'b1;
    if (occ == CAP) begin
      tick(10);
      chk("full_reject_status", int'(status), 0);
      chk("full_reject_red", int'(red_light), 1);
      sense_entry = 1'b0;
      tick(6);
      check_counts("full_reject");
      return;
    end
    wait_status(1, 20, "enter_wait");
    for (int k = 0; k < nwrong; k++) begin
      wrong_code(v);
      strobe(v);
      wait_status(3, 5, "deny");
    end
    strobe(4'h5);
    wait_status(2, 5, "grant");
    chk("grant_green", int'(green_light), 1);
    sense_entry = 1'b0;
    wait_status(0, 10, "admit_idle");
    occ++;
    total++;
    check_counts("admit");
  endtask

  task automatic exit_car();
    sense_exit = 1'b1;
    tick(6);
    sense_exit = 1'b0;
    tick(6);
    if (occ > 0) occ--;
    check_counts("exit");
  endtask

  task automatic abandon();
    if (occ == CAP) begin
      admit_car(0);
      return;
    end
    sense_entry = 1'b1;
    wait_status(1, 20, "abandon_wait");
    sense_entry = 1'b0;
    wait_status(0, 10, "abandon_idle");
    check_counts("abandon");
  endtask

  // Entry fall and exit rise land on the same cycle through equal-latency paths.
  task automatic simultaneous();
    if (occ == 0 || occ == CAP) begin
      admit_car(0);
      return;
    end
    sense_entry = 1'b1;
    wait_status(1, 20, "sim_wait");
    strobe(4'h5);
    wait_status(2, 5, "sim_grant");
    sense_entry = 1'b0;
    sense_exit  = 1'b1;
    wait_status(0, 10, "sim_idle");
    tick();
    total++;
    check_counts("simultaneous");
    sense_exit = 1'b0;
    tick(6);
  endtask

  task automatic lockout();
    int n = 0;
    sense_entry = 1'b1;
    wait_status(1, 20, "lock_wait");
    for (int k = 0; k < 3; k++) begin
      strobe(4'h3);
      tick();
    end
    wait_status(5, 5, "lock_status");
    chk("lock_flag", int'(locked), 1);
    while (locked && n < LOCKN + 200) begin
      tick();
      n++;
    end
    chk("lock_len", n, LOCKN);
    chk("lock_exit_status", int'(status), 0);
    sense_entry = 1'b0;
    tick(6);
    check_counts("lockout");
  endtask

  task automatic stall();
    sense_entry = 1'b1;
    wait_status(1, 20, "stall_wait");
    strobe(4'h5);
    wait_status(2, 5, "stall_grant");
    tick(1900);
    chk("stall_still_grant", int'(status), 2);
    wait_status(4, 200, "stall_stop");
    strobe(4'h5);
    tick(3);
    chk("stop_hold", int'(status), 4);
    sense_entry = 1'b0;
    tick(6);
    strobe(4'h5);
    wait_status(0, 5, "stop_release");
    check_counts("stall");
  endtask

  task automatic timeout();
    sense_entry = 1'b1;
    wait_status(1, 20, "to_wait");
    tick(900);
    chk("to_still_wait", int'(status), 1);
    wait_status(0, 200, "to_idle");
    sense_entry = 1'b0;
    tick(6);
    check_counts("timeout");
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_green"},  int'(green_light), 0);
    chk({tag, "_red"},    int'(red_light), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_status"}, int'(status), 0);
    check_counts(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int op;
    tick(3);
    check_reset("reset");
    rst = 1'b0;
    tick(2);

    exit_car();
    admit_car(0);
    lockout();

    repeat (14) begin
      op = $urandom_range(0, 3);
      case (op)
        0: admit_car($urandom_range(0, 2));
        1: exit_car();
        2: abandon();
        default: simultaneous();
      endcase
    end

    while (occ < CAP) admit_car(0);
    tick(2);
    chk("full_flag", int'(full), 1);
    chk("full_red", int'(red_light), 1);
    admit_car(0);
    exit_car();
    chk("unfull", int'(full), 0);

    simultaneous();
    stall();
    timeout();

    sense_entry = 1'b1;
    wait_status(1, 20, "rst_wait");
    strobe(4'h5);
    wait_status(2, 5, "rst_grant");
    rst = 1'b1;
    sense_entry = 1'b0;
    tick(2);
    occ   = 0;
    total = 0;
    check_reset("mid_reset");
    rst = 1'b0;
    tick(6);
    check_counts("post_reset");
    exit_car();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
